// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: default offset width, state encodings, NOP encoding.
`ifndef FETCH_SEQ_DEFS
`define FETCH_SEQ_DEFS
`define MAX_LENGTH 32
`endif

package fetch_seq_pkg;

    typedef enum logic [1:0] {
        FS_RUN      = 2'd0,
        FS_MEM_WAIT = 2'd1,
        FS_FLUSH    = 2'd2
    } fs_state_e;

    // addi x0, x0, 0 -- what the ID/EX register carries when bubbled
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_seq_pend_reg.sv
// One-entry pending-branch holder: the first set wins until cleared.
module fetch_seq_pend_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set_i,
    input  logic         clr_i,
    input  logic [W-1:0] offset_i,
    output logic         valid_o,
    output logic [W-1:0] offset_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] offset_q, offset_d;

    always_comb begin
        valid_d  = valid_q;
        offset_d = offset_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (set_i && !valid_q) begin
            valid_d  = 1'b1;
            offset_d = offset_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            offset_q <= '0;
        end else begin
            valid_q  <= valid_d;
            offset_q <= offset_d;
        end
    end

    assign valid_o  = valid_q;
    assign offset_o = offset_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage pipeline control: redirects, load-use bubbles, memory-stall freezes with branch replay.
// Optional performance counters are built when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int WIDTH        = `MAX_LENGTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_taken_in,
    input  logic [WIDTH-1:0] br_offset_in,
    input  logic             hazard_in,
    input  logic             mem_busy,
    output logic             if_freeze,
    output logic             pipe_freeze,
    output logic             id_bubble,
    output logic             flush,
    output logic             br_taken_out,
    output logic [WIDTH-1:0] br_offset_out,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic       REDIR_FLUSH = (FLUSH_CYCLES > 1);

    fs_state_e        state_q, state_d;
    logic [2:0]       flush_ctr_q, flush_ctr_d;
    logic             pend_set, pend_clr, pend_valid, run_rules;
    logic [WIDTH-1:0] pend_offset;

    fetch_seq_pend_reg #(.W(WIDTH)) u_pend (
        .clk      (clk),
        .reset    (reset),
        .set_i    (pend_set),
        .clr_i    (pend_clr),
        .offset_i (br_offset_in),
        .valid_o  (pend_valid),
        .offset_o (pend_offset)
    );

    always_comb begin
        state_d       = state_q;
        flush_ctr_d   = flush_ctr_q;
        pend_set      = 1'b0;
        pend_clr      = 1'b0;
        run_rules     = 1'b0;
        if_freeze     = 1'b0;
        pipe_freeze   = 1'b0;
        id_bubble     = 1'b0;
        flush         = 1'b0;
        br_taken_out  = 1'b0;
        br_offset_out = '0;

        case (state_q)
            FS_RUN: begin
                if (mem_busy) begin
                    if_freeze   = 1'b1;
                    pipe_freeze = 1'b1;
                    pend_set    = br_taken_in;
                    state_d     = FS_MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            FS_MEM_WAIT: begin
                if (mem_busy) begin
                    if_freeze   = 1'b1;
                    pipe_freeze = 1'b1;
                    pend_set    = br_taken_in;
                end else if (pend_valid) begin
                    br_taken_out  = 1'b1;
                    br_offset_out = pend_offset;
                    pend_clr      = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            FS_FLUSH: begin
                // Branch/hazard inputs here belong to squashed instructions
                flush = 1'b1;
                if (mem_busy) begin
                    if_freeze   = 1'b1;
                    pipe_freeze = 1'b1;
                end else if (flush_ctr_q <= 3'd1) begin
                    flush_ctr_d = 3'd0;
                    state_d     = FS_RUN;
                end else begin
                    flush_ctr_d = flush_ctr_q - 3'd1;
                end
            end
            default: state_d = FS_RUN;
        endcase

        if (run_rules) begin
            state_d = FS_RUN;
            if (br_taken_in) begin
                br_taken_out  = 1'b1;
                br_offset_out = br_offset_in;
            end else if (hazard_in) begin
                if_freeze = 1'b1;
                id_bubble = 1'b1;
            end
        end

        // Every redirect, live or replayed, opens a flush window
        if (br_taken_out) begin
            flush       = 1'b1;
            flush_ctr_d = FLUSH_LOAD;
            state_d     = REDIR_FLUSH ? FS_FLUSH : FS_RUN;
        end

        if (reset) begin
            if_freeze     = 1'b0;
            pipe_freeze   = 1'b0;
            id_bubble     = 1'b0;
            flush         = 1'b0;
            br_taken_out  = 1'b0;
            br_offset_out = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_RUN;
            flush_ctr_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
        end
    end

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(if_freeze);
            flush_cnt_q <= flush_cnt_q + 32'(br_taken_out);
        end
    end

    assign stall_cnt = reset ? 32'd0 : stall_cnt_q;
    assign flush_cnt = reset ? 32'd0 : flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random traffic against a reference model.
module tb_fetch_sequencer;

    localparam int FC = 2;

    logic        clk, reset, br_taken_in, hazard_in, mem_busy;
    logic [31:0] br_offset_in;
    logic        if_freeze, pipe_freeze, id_bubble, flush, br_taken_out;
    logic [31:0] br_offset_out, stall_cnt, flush_cnt;

    fetch_sequencer #(.WIDTH(32), .FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_taken_in   (br_taken_in),
        .br_offset_in  (br_offset_in),
        .hazard_in     (hazard_in),
        .mem_busy      (mem_busy),
        .if_freeze     (if_freeze),
        .pipe_freeze   (pipe_freeze),
        .id_bubble     (id_bubble),
        .flush         (flush),
        .br_taken_out  (br_taken_out),
        .br_offset_out (br_offset_out),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ifz;
        logic        pfz;
        logic        bub;
        logic        fl;
        logic        bt;
        logic [31:0] off;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: no states, just "flush cycles still owed", a pending-redirect list and counts.
    int          m_flush_left = 0;
    logic [31:0] m_pend[$];
    logic [31:0] m_stall = 0;
    logic [31:0] m_redir = 0;

    function automatic exp_t model(input logic r, bt, input logic [31:0] off,
                                   input logic hz, mb);
        exp_t e;
        e = '0;
        if (r) begin
            m_flush_left = 0;
            m_pend.delete();
            m_stall = 0;
            m_redir = 0;
            return e;
        end
`ifdef FETCH_SEQ_PERF_CNT_EN
        e.sc = m_stall;
        e.fc = m_redir;
`endif
        if (m_flush_left > 0) begin
            e.fl = 1'b1;
            if (mb) begin
                e.ifz = 1'b1;
                e.pfz = 1'b1;
            end else begin
                m_flush_left--;
            end
        end else if (mb) begin
            e.ifz = 1'b1;
            e.pfz = 1'b1;
            if (bt && m_pend.size() == 0) m_pend.push_back(off);
        end else if (m_pend.size() != 0) begin
            e.bt  = 1'b1;
            e.off = m_pend.pop_front();
        end else if (bt) begin
            e.bt  = 1'b1;
            e.off = off;
        end else if (hz) begin
            e.ifz = 1'b1;
            e.bub = 1'b1;
        end
        if (e.bt) begin
            e.fl = 1'b1;
            m_flush_left = FC - 1;
        end
        m_stall += 32'(e.ifz);
        m_redir += 32'(e.bt);
        return e;
    endfunction

    task automatic step(input string tag, input logic r, bt, input logic [31:0] off,
                        input logic hz, mb);
        @(posedge clk);
        #1;
        reset        = r;
        br_taken_in  = bt;
        br_offset_in = off;
        hazard_in    = hz;
        mem_busy     = mb;
        exp_q.push_back(model(r, bt, off, hz, mb));
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{if_freeze, pipe_freeze, id_bubble, flush, br_taken_out,
                  br_offset_out, stall_cnt, flush_cnt};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got ifz=%b pfz=%b bub=%b fl=%b bt=%b off=%h sc=%0d fc=%0d, want ifz=%b pfz=%b bub=%b fl=%b bt=%b off=%h sc=%0d fc=%0d",
                         t, $time, a.ifz, a.pfz, a.bub, a.fl, a.bt, a.off, a.sc, a.fc,
                         e.ifz, e.pfz, e.bub, e.fl, e.bt, e.off, e.sc, e.fc);
            end
        end
    end

    initial begin
        reset = 1'b1; br_taken_in = 1'b0; br_offset_in = '0; hazard_in = 1'b0; mem_busy = 1'b0;

        for (int i = 0; i < 3; i++) step("reset_busy", 1'b1, 1'b1, 32'hdead, 1'b1, 1'b1);
        idle("post_reset", 1);

        step("br_issue", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        step("br_squash", 1'b0, 1'b1, 32'h44, 1'b1, 1'b0);
        idle("br_after", 2);

        step("hazard", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("hazard", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle("hazard_after", 1);

        step("mem_c1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step("mem_c2", 1'b0, 1'b1, 32'h5, 1'b0, 1'b1);
        step("mem_c3", 1'b0, 1'b1, 32'h9, 1'b0, 1'b1);
        step("mem_c4", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle("mem_replay", 4);

        step("fl_issue", 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("fl_busy", 1'b0, 1'b1, 32'h30, 1'b1, 1'b1);
        idle("fl_release", 3);

        step("cnt_reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("cnt_hz", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("cnt_br1", 1'b0, 1'b1, 32'h7, 1'b0, 1'b0);
        idle("cnt_gap", 2);
        step("cnt_br2", 1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
        idle("cnt_end", 3);

        step("mid_reset_setup", 1'b0, 1'b1, 32'h55, 1'b0, 1'b1);
        step("mid_reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle("mid_reset_after", 3);

        for (int i = 0; i < 3000; i++)
            step("random", ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) == 0), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        idle("drain", 3);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
